// File: rtl/led_fader.sv
// rtl/led_fader.sv - four-channel LED fader: synchronized on/off targets ramp PWM brightness up/down one step per tick
module led_fader #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 65536
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] led_in,
   output logic [3:0] leds,
   output logic       fading
);

   localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic [3:0]          sync1;
   logic [3:0]          target;
   logic [PRE_W-1:0]    pre_cnt;
   logic                tick;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] level [4];
   logic [PWM_BITS-1:0] level_next [4];
   logic [3:0]          rise;
   logic [3:0]          fall;
   logic [3:0]          pwm_out;

   assign tick = (pre_cnt == PRE_LAST);

   // Channel state is implied by (level, target): RISE and FALL move, OFF and ON hold.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rise[i]       = target[i] && (level[i] != MAX);
         fall[i]       = !target[i] && (level[i] != '0);
         level_next[i] = level[i];
         if (rise[i])
            level_next[i] = level[i] + 1'b1;
         else if (fall[i])
            level_next[i] = level[i] - 1'b1;
         pwm_out[i]    = (level[i] == MAX) || (pwm_cnt < level[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         target  <= '0;
         pre_cnt <= '0;
         pwm_cnt <= '0;
         leds    <= '0;
         fading  <= 1'b0;
         for (int i = 0; i < 4; i++)
            level[i] <= '0;
      end else begin
         sync1   <= led_in;
         target  <= sync1;
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         pwm_cnt <= pwm_cnt + 1'b1;
         leds    <= pwm_out;
         fading  <= |(rise | fall);
         if (tick) begin
            for (int i = 0; i < 4; i++)
               level[i] <= level_next[i];
         end
      end
   end

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - self-checking bench for led_fader against a cycle-level reference model
module tb_led_fader;

   localparam int PWM_BITS = 4;
   localparam int STEP     = 2;
   localparam int MAXV     = (1 << PWM_BITS) - 1;

   logic       clk;
   logic       rst;
   logic [3:0] led_in;
   logic [3:0] leds;
   logic       fading;

   int vectors     = 0;
   int miscompares = 0;

   int         m_lvl [4];
   logic [3:0] m_s1, m_s2;
   int         m_pre, m_pwm;
   logic [3:0] m_leds;
   logic       m_fad;

   led_fader #(.PWM_BITS(PWM_BITS), .STEP_CYCLES(STEP)) dut (
      .clk    (clk),
      .rst    (rst),
      .led_in (led_in),
      .leds   (leds),
      .fading (fading)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: targets are MAX/0, levels walk one unit toward them each STEP-th cycle.
   task automatic step_model(input logic r, input logic [3:0] d);
      int         nl [4];
      int         goal;
      logic [3:0] nleds;
      logic       nfad;
      logic       tick;
      if (r) begin
         for (int i = 0; i < 4; i++) m_lvl[i] = 0;
         m_s1 = '0; m_s2 = '0; m_pre = 0; m_pwm = 0; m_leds = '0; m_fad = 1'b0;
      end else begin
         tick = (m_pre == STEP - 1);
         nfad = 1'b0;
         for (int i = 0; i < 4; i++) begin
            goal     = m_s2[i] ? MAXV : 0;
            nleds[i] = (m_lvl[i] == MAXV) || (m_pwm < m_lvl[i]);
            if (m_lvl[i] != goal) nfad = 1'b1;
            nl[i] = m_lvl[i];
            if (tick && m_lvl[i] < goal) nl[i] = m_lvl[i] + 1;
            else if (tick && m_lvl[i] > goal) nl[i] = m_lvl[i] - 1;
         end
         for (int i = 0; i < 4; i++) m_lvl[i] = nl[i];
         m_leds = nleds;
         m_fad  = nfad;
         m_pwm  = (m_pwm + 1) % (MAXV + 1);
         m_pre  = (m_pre + 1) % STEP;
         m_s2   = m_s1;
         m_s1   = d;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      step_model(rst, led_in);
      #1;
      vectors++;
      assert (leds === m_leds) else begin
         miscompares++;
         $error("FAIL leds observed=%b expected=%b t=%0t", leds, m_leds, $time);
      end
      vectors++;
      assert (fading === m_fad) else begin
         miscompares++;
         $error("FAIL fading observed=%b expected=%b t=%0t", fading, m_fad, $time);
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   initial begin
      rst = 1'b1;
      led_in = 4'hF;
      run(3);
      chk("reset_leds", leds, 4'h0);
      chk("reset_fading", {3'b0, fading}, 4'h0);

      rst = 1'b0;
      run(3);
      chk("fading_after_sync", {3'b0, fading}, 4'h1);

      run(40);
      chk("full_on_leds", leds, 4'hF);
      run(100);
      chk("hold_on_leds", leds, 4'hF);
      chk("hold_on_fading", {3'b0, fading}, 4'h0);

      led_in = 4'h0;
      run(40);
      chk("full_off_leds", leds, 4'h0);
      run(20);
      chk("hold_off_leds", leds, 4'h0);
      chk("hold_off_fading", {3'b0, fading}, 4'h0);

      // Reversals mid-ramp on channel 0.
      led_in = 4'b0001;
      for (int k = 0; k < 200 && m_lvl[0] != 5; k++) cyc();
      led_in = 4'b0000;
      for (int k = 0; k < 200 && m_lvl[0] != 3; k++) cyc();
      led_in = 4'b0001;
      run(40);
      chk("ramp_back_on", leds, 4'b0001);

      // Reset pulse at level 9 on all channels.
      led_in = 4'h0;
      run(40);
      led_in = 4'hF;
      for (int k = 0; k < 200 && m_lvl[3] != 9; k++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_pulse_leds", leds, 4'h0);
      chk("rst_pulse_fading", {3'b0, fading}, 4'h0);
      run(50);

      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 15) == 0) led_in = 4'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 1'b0;
      run(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
